// File: rtl/count_cdc_rx.sv
// Receives a Gray-coded counter from a foreign clock domain. It synchronizes and
// decodes the counter, then reports accepted increments, a running total and step errors.
module count_cdc_rx #(
   parameter int WIDTH       = 16,
   parameter int SYNC_STAGES = 2,
   parameter int MAX_STEP    = 1
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] gray_in,
   input  logic             clear,
   output logic [WIDTH-1:0] count,
   output logic [WIDTH-1:0] delta,
   output logic             upd,
   output logic             step_err,
   output logic [31:0]      total
);

   typedef enum logic [1:0] {FILL, BASE, RUN} state_t;

   localparam int SUM_W = ((WIDTH > 32) ? WIDTH : 32) + 1;

   state_t           state_q, state_d;
   logic [2:0]       fill_cnt_q, fill_cnt_d;
   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [WIDTH-1:0] decoded;
   logic [WIDTH-1:0] diff;
   logic [SUM_W-1:0] sum;
   logic [WIDTH-1:0] count_d, delta_d;
   logic             upd_d, step_err_d;
   logic [31:0]      total_d;

   // Plain flop chain; gray_in is only ever observed through its last stage
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
         sync_q[0] <= gray_in;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   always_comb begin
      decoded = '0;
      decoded[WIDTH-1] = sync_q[SYNC_STAGES-1][WIDTH-1];
      for (int i = WIDTH - 2; i >= 0; i--) decoded[i] = decoded[i+1] ^ sync_q[SYNC_STAGES-1][i];
   end

   assign diff = decoded - count;
   assign sum  = SUM_W'(total) + SUM_W'(diff);

   // Next-state and output logic; clear always overrides a pending update
   always_comb begin
      state_d    = state_q;
      fill_cnt_d = fill_cnt_q;
      count_d    = count;
      delta_d    = delta;
      upd_d      = 1'b0;
      step_err_d = step_err;
      total_d    = total;
      case (state_q)
         FILL: begin
            fill_cnt_d = fill_cnt_q + 3'd1;
            if (fill_cnt_q == 3'(SYNC_STAGES - 1)) begin
               state_d    = BASE;
               fill_cnt_d = '0;
            end
            if (clear) begin
               total_d    = '0;
               step_err_d = 1'b0;
            end
         end
         BASE: begin
            if (clear) begin
               total_d    = '0;
               step_err_d = 1'b0;
            end else begin
               count_d = decoded;
               state_d = RUN;
            end
         end
         RUN: begin
            if (clear) begin
               total_d    = '0;
               step_err_d = 1'b0;
               state_d    = BASE;
            end else if (diff != '0) begin
               count_d = decoded;
               delta_d = diff;
               upd_d   = 1'b1;
               total_d = (sum > SUM_W'(32'hFFFF_FFFF)) ? 32'hFFFF_FFFF : sum[31:0];
               if (SUM_W'(diff) > SUM_W'(MAX_STEP)) step_err_d = 1'b1;
            end
         end
         default: state_d = FILL;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= FILL;
         fill_cnt_q <= '0;
         count      <= '0;
         delta      <= '0;
         upd        <= 1'b0;
         step_err   <= 1'b0;
         total      <= '0;
      end else begin
         state_q    <= state_d;
         fill_cnt_q <= fill_cnt_d;
         count      <= count_d;
         delta      <= delta_d;
         upd        <= upd_d;
         step_err   <= step_err_d;
         total      <= total_d;
      end
   end

endmodule

// File: tb/tb_count_cdc_rx.sv
// Directed bench for count_cdc_rx (WIDTH=16, SYNC_STAGES=2, MAX_STEP=1).
// Each scenario task computes its expected values by hand.
module tb_count_cdc_rx;

   logic        clock = 1'b0;
   logic        reset_n;
   logic [15:0] gray_in;
   logic        clear;
   logic [15:0] count, delta;
   logic        upd, step_err;
   logic [31:0] total;

   int n_checks = 0;
   int n_bad    = 0;

   count_cdc_rx #(.WIDTH(16), .SYNC_STAGES(2), .MAX_STEP(1)) dut (
      .clock(clock), .reset_n(reset_n), .gray_in(gray_in), .clear(clear),
      .count(count), .delta(delta), .upd(upd), .step_err(step_err), .total(total)
   );

   always #5 clock = ~clock;

   function automatic logic [15:0] to_gray(input logic [15:0] b);
      return b ^ (b >> 1);
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      clear   = 1'b0;
      gray_in = 16'h0005;
      tick(); tick();
      n_checks++; if (count !== 16'd0) begin $display("FAIL reset_count got=%0d want=0", count); n_bad++; end
      n_checks++; if ({upd, step_err} !== 2'b00) begin $display("FAIL reset_flags got=%b want=00", {upd, step_err}); n_bad++; end
      n_checks++; if (total !== 32'd0) begin $display("FAIL reset_total got=%0d want=0", total); n_bad++; end
      reset_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         n_checks++; if (upd !== 1'b0) begin $display("FAIL fill_upd edge=%0d got=%b want=0", i, upd); n_bad++; end
      end
      tick();
      n_checks++; if (count !== 16'd6) begin $display("FAIL base_count got=%0d want=6", count); n_bad++; end
      n_checks++; if (upd !== 1'b0) begin $display("FAIL base_upd got=%b want=0", upd); n_bad++; end
      n_checks++; if (delta !== 16'd0) begin $display("FAIL base_delta got=%0d want=0", delta); n_bad++; end
      n_checks++; if (total !== 32'd0) begin $display("FAIL base_total got=%0d want=0", total); n_bad++; end
   endtask

   task automatic test_increment();
      for (int v = 7; v <= 9; v++) begin
         gray_in = to_gray(16'(v));
         tick();
         n_checks++; if (upd !== 1'b0) begin $display("FAIL inc_early1 v=%0d got=%b want=0", v, upd); n_bad++; end
         tick();
         n_checks++; if (upd !== 1'b0) begin $display("FAIL inc_early2 v=%0d got=%b want=0", v, upd); n_bad++; end
         tick();
         n_checks++; if (upd !== 1'b1) begin $display("FAIL inc_upd v=%0d got=%b want=1", v, upd); n_bad++; end
         n_checks++; if (count !== 16'(v)) begin $display("FAIL inc_count got=%0d want=%0d", count, v); n_bad++; end
         n_checks++; if (delta !== 16'd1) begin $display("FAIL inc_delta v=%0d got=%0d want=1", v, delta); n_bad++; end
      end
      n_checks++; if (total !== 32'd3) begin $display("FAIL inc_total got=%0d want=3", total); n_bad++; end
      n_checks++; if (step_err !== 1'b0) begin $display("FAIL inc_step_err got=%b want=0", step_err); n_bad++; end
   endtask

   task automatic test_jump();
      gray_in = to_gray(16'd13);
      tick(); tick(); tick();
      n_checks++; if (upd !== 1'b1) begin $display("FAIL jump_upd got=%b want=1", upd); n_bad++; end
      n_checks++; if (delta !== 16'd4) begin $display("FAIL jump_delta got=%0d want=4", delta); n_bad++; end
      n_checks++; if (total !== 32'd7) begin $display("FAIL jump_total got=%0d want=7", total); n_bad++; end
      n_checks++; if (step_err !== 1'b1) begin $display("FAIL jump_step_err got=%b want=1", step_err); n_bad++; end
      tick(); tick();
      n_checks++; if ({upd, step_err} !== 2'b01) begin $display("FAIL jump_sticky got=%b want=01", {upd, step_err}); n_bad++; end
      clear = 1'b1;
      tick();
      clear = 1'b0;
      n_checks++; if ({upd, step_err} !== 2'b00) begin $display("FAIL jump_clear_flags got=%b want=00", {upd, step_err}); n_bad++; end
      n_checks++; if (total !== 32'd0) begin $display("FAIL jump_clear_total got=%0d want=0", total); n_bad++; end
      tick();
      n_checks++; if (count !== 16'd13 || upd !== 1'b0) begin $display("FAIL jump_rebase count=%0d upd=%b want 13/0", count, upd); n_bad++; end
   endtask

   task automatic test_wrap();
      gray_in = to_gray(16'hFFFF);
      tick(); tick();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      n_checks++; if (upd !== 1'b0 || total !== 32'd0) begin $display("FAIL wrap_clear upd=%b total=%0d want 0/0", upd, total); n_bad++; end
      tick();
      n_checks++; if (count !== 16'hFFFF) begin $display("FAIL wrap_base got=%h want=ffff", count); n_bad++; end
      gray_in = to_gray(16'h0000);
      tick(); tick(); tick();
      n_checks++; if (upd !== 1'b1) begin $display("FAIL wrap_upd got=%b want=1", upd); n_bad++; end
      n_checks++; if (count !== 16'd0) begin $display("FAIL wrap_count got=%h want=0", count); n_bad++; end
      n_checks++; if (delta !== 16'd1) begin $display("FAIL wrap_delta got=%0d want=1", delta); n_bad++; end
      n_checks++; if (step_err !== 1'b0) begin $display("FAIL wrap_step_err got=%b want=0", step_err); n_bad++; end
      n_checks++; if (total !== 32'd1) begin $display("FAIL wrap_total got=%0d want=1", total); n_bad++; end
   endtask

   task automatic test_clear_collision();
      gray_in = to_gray(16'd20);
      tick(); tick(); tick();
      n_checks++; if (delta !== 16'd20 || total !== 32'd21) begin $display("FAIL coll_pre delta=%0d total=%0d want 20/21", delta, total); n_bad++; end
      n_checks++; if (step_err !== 1'b1) begin $display("FAIL coll_pre_err got=%b want=1", step_err); n_bad++; end
      gray_in = to_gray(16'd21);
      tick(); tick();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      n_checks++; if (upd !== 1'b0) begin $display("FAIL coll_upd got=%b want=0", upd); n_bad++; end
      n_checks++; if (total !== 32'd0 || step_err !== 1'b0) begin $display("FAIL coll_clear total=%0d err=%b want 0/0", total, step_err); n_bad++; end
      n_checks++; if (count !== 16'd20) begin $display("FAIL coll_hold got=%0d want=20", count); n_bad++; end
      tick();
      n_checks++; if (count !== 16'd21 || upd !== 1'b0) begin $display("FAIL coll_base count=%0d upd=%b want 21/0", count, upd); n_bad++; end
      tick();
      n_checks++; if (upd !== 1'b0 || total !== 32'd0) begin $display("FAIL coll_after upd=%b total=%0d want 0/0", upd, total); n_bad++; end
   endtask

   task automatic test_reset_midflight();
      gray_in = to_gray(16'd22);
      tick(); tick(); tick();
      n_checks++; if (upd !== 1'b1 || total !== 32'd1) begin $display("FAIL mid_pre upd=%b total=%0d want 1/1", upd, total); n_bad++; end
      gray_in = to_gray(16'd30);
      tick();
      reset_n = 1'b0;
      #1;
      n_checks++; if ({count, delta} !== 32'd0) begin $display("FAIL mid_reset count=%0d delta=%0d want 0/0", count, delta); n_bad++; end
      n_checks++; if ({upd, step_err} !== 2'b00 || total !== 32'd0) begin $display("FAIL mid_reset_flags flags=%b total=%0d want 00/0", {upd, step_err}, total); n_bad++; end
      tick(); tick();
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++; if (upd !== 1'b0) begin $display("FAIL mid_refill_upd edge=%0d got=%b want=0", i, upd); n_bad++; end
      end
      n_checks++; if (count !== 16'd30) begin $display("FAIL mid_base got=%0d want=30", count); n_bad++; end
      n_checks++; if (delta !== 16'd0 || total !== 32'd0) begin $display("FAIL mid_base_acc delta=%0d total=%0d want 0/0", delta, total); n_bad++; end
      tick();
      n_checks++; if (upd !== 1'b0) begin $display("FAIL mid_settle got=%b want=0", upd); n_bad++; end
   endtask

   initial begin
      test_reset();
      test_increment();
      test_jump();
      test_wrap();
      test_clear_collision();
      test_reset_midflight();
      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule
